// File: rtl/ahb_op_sequencer_pkg.sv
// Shared definitions for the AHB-lite operation sequencer: bus codes,
// slave register offsets, FSM encoding and the step-to-offset helper.
package ahb_op_sequencer_pkg;

   localparam logic [1:0]  HTRANS_IDLE   = 2'b00;
   localparam logic [1:0]  HTRANS_NONSEQ = 2'b10;
   localparam logic [2:0]  HSIZE_WORD    = 3'b010;
   localparam logic [2:0]  HBURST_SINGLE = 3'b000;

   // Slave register map, relative to the selected slave base
   localparam logic [31:0] OFF_A   = 32'h0000_0000;
   localparam logic [31:0] OFF_B   = 32'h0000_0004;
   localparam logic [31:0] OFF_OP  = 32'h0000_0008;
   localparam logic [31:0] OFF_RES = 32'h0000_000C;

   // Transfer steps of one command, in issue order
   localparam logic [1:0]  STEP_A   = 2'd0;
   localparam logic [1:0]  STEP_B   = 2'd1;
   localparam logic [1:0]  STEP_OP  = 2'd2;
   localparam logic [1:0]  STEP_RES = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_ADDR = 2'b01,
      ST_DATA = 2'b10,
      ST_RESP = 2'b11
   } seq_state_e;

   // Register offset addressed by a given transfer step
   function automatic logic [31:0] step_offset(input logic [1:0] step);
      logic [31:0] off_v;
      case (step)
         STEP_A:   off_v = OFF_A;
         STEP_B:   off_v = OFF_B;
         STEP_OP:  off_v = OFF_OP;
         STEP_RES: off_v = OFF_RES;
         default:  off_v = OFF_RES;
      endcase
      return off_v;
   endfunction

endpackage

// File: rtl/op_cmd_fifo.sv
// Synchronous FIFO holding queued operation commands. Depth must be a power
// of two so the pointers wrap naturally; count spans 0..DEPTH.
module op_cmd_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4,
   localparam int AW   = $clog2(DEPTH),
   localparam int CW   = AW + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic [CW-1:0]    count,
   output logic             full,
   output logic             empty
);

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [AW-1:0]    wr_ptr_r;
   logic [AW-1:0]    rd_ptr_r;
   logic [CW-1:0]    count_r;
   logic             push_ok_s;
   logic             pop_ok_s;

   assign full      = (count_r == CW'(DEPTH));
   assign empty     = (count_r == CW'(0));
   assign count     = count_r;
   assign pop_data  = mem_r[rd_ptr_r];
   assign push_ok_s = push & ~full;
   assign pop_ok_s  = pop & ~empty;

   // Pointer and occupancy bookkeeping
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_r <= AW'(0);
         rd_ptr_r <= AW'(0);
         count_r  <= CW'(0);
      end else begin
         if (push_ok_s) begin
            wr_ptr_r <= wr_ptr_r + AW'(1);
         end
         if (pop_ok_s) begin
            rd_ptr_r <= rd_ptr_r + AW'(1);
         end
         case ({push_ok_s, pop_ok_s})
            2'b10:   count_r <= count_r + CW'(1);
            2'b01:   count_r <= count_r - CW'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   // Storage write; contents need no reset since empty gates every read
   always_ff @(posedge clk) begin
      if (push_ok_s) begin
         mem_r[wr_ptr_r] <= push_data;
      end
   end

endmodule

// File: rtl/ahb_op_sequencer.sv
// AHB-lite single master: pops queued {target, op, A, B} commands and runs
// each as write A, write B, write opcode, read result on the chosen slave,
// then holds the result on a valid/ready response port.
module ahb_op_sequencer
   import ahb_op_sequencer_pkg::*;
#(
   parameter int          CMD_DEPTH = 4,
   parameter logic [31:0] ALU_BASE  = 32'h0000_0000,
   parameter logic [31:0] MUL_BASE  = 32'h0000_1000,
   parameter int          W_OP      = 4
) (
   input  logic            HCLK,
   input  logic            HRESET,
   input  logic            cmd_valid,
   output logic            cmd_ready,
   input  logic            cmd_target,
   input  logic [W_OP-1:0] cmd_op,
   input  logic [31:0]     cmd_a,
   input  logic [31:0]     cmd_b,
   output logic            rsp_valid,
   input  logic            rsp_ready,
   output logic [31:0]     rsp_data,
   output logic            rsp_err,
   output logic            busy,
   output logic [31:0]     o_HADDR,
   output logic [31:0]     o_HWDATA,
   output logic            o_HWRITE,
   output logic [2:0]      o_HSIZE,
   output logic [2:0]      o_HBURST,
   output logic [1:0]      o_HTRANS,
   input  logic [31:0]     i_HRDATA,
   input  logic [1:0]      i_HRESP,
   input  logic            i_HREADY
);

   localparam int CMD_W = 1 + W_OP + 32 + 32;
   localparam int CNT_W = $clog2(CMD_DEPTH) + 1;

   seq_state_e       state_r;
   logic [1:0]       step_r;
   logic             target_r;
   logic [W_OP-1:0]  op_r;
   logic [31:0]      a_r;
   logic [31:0]      b_r;

   logic             push_s;
   logic             pop_s;
   logic [CMD_W-1:0] push_data_s;
   logic [CMD_W-1:0] head_s;
   logic [CNT_W-1:0] count_s;
   logic             full_s;
   logic             empty_s;

   logic             head_target_s;
   logic [W_OP-1:0]  head_op_s;
   logic [31:0]      head_a_s;
   logic [31:0]      head_b_s;
   logic [31:0]      head_base_s;
   logic [31:0]      work_base_s;
   logic [1:0]       next_step_s;
   logic [31:0]      wr_data_s;
   logic             slave_err_s;
   logic             unused_hresp_s;

   assign push_s      = cmd_valid & ~full_s;
   assign push_data_s = {cmd_target, cmd_op, cmd_a, cmd_b};

   op_cmd_fifo #(
      .WIDTH (CMD_W),
      .DEPTH (CMD_DEPTH)
   ) u_cmd_fifo (
      .clk       (HCLK),
      .rst       (HRESET),
      .push      (push_s),
      .push_data (push_data_s),
      .pop       (pop_s),
      .pop_data  (head_s),
      .count     (count_s),
      .full      (full_s),
      .empty     (empty_s)
   );

   assign {head_target_s, head_op_s, head_a_s, head_b_s} = head_s;

   assign head_base_s    = head_target_s ? MUL_BASE : ALU_BASE;
   assign work_base_s    = target_r ? MUL_BASE : ALU_BASE;
   assign next_step_s    = step_r + 2'd1;
   assign slave_err_s    = i_HRESP[0];
   assign unused_hresp_s = i_HRESP[1];

   assign cmd_ready = ~full_s;
   assign busy      = (state_r != ST_IDLE) || (count_s != CNT_W'(0));
   assign o_HSIZE   = HSIZE_WORD;
   assign o_HBURST  = HBURST_SINGLE;

   // Pop the head only when idle with no response still held
   always_comb begin
      pop_s = 1'b0;
      if ((state_r == ST_IDLE) && !empty_s && !rsp_valid) begin
         pop_s = 1'b1;
      end else begin
         pop_s = 1'b0;
      end
   end

   // Write data presented in the data phase of each write step
   always_comb begin
      wr_data_s = a_r;
      case (step_r)
         STEP_A:  wr_data_s = a_r;
         STEP_B:  wr_data_s = b_r;
         STEP_OP: wr_data_s = 32'(op_r);
         default: wr_data_s = a_r;
      endcase
   end

   // Transfer sequencer with registered bus and response outputs
   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         state_r   <= ST_IDLE;
         step_r    <= STEP_A;
         target_r  <= 1'b0;
         op_r      <= W_OP'(0);
         a_r       <= 32'h0000_0000;
         b_r       <= 32'h0000_0000;
         rsp_valid <= 1'b0;
         rsp_data  <= 32'h0000_0000;
         rsp_err   <= 1'b0;
         o_HTRANS  <= HTRANS_IDLE;
         o_HADDR   <= 32'h0000_0000;
         o_HWDATA  <= 32'h0000_0000;
         o_HWRITE  <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (pop_s) begin
                  target_r <= head_target_s;
                  op_r     <= head_op_s;
                  a_r      <= head_a_s;
                  b_r      <= head_b_s;
                  step_r   <= STEP_A;
                  o_HTRANS <= HTRANS_NONSEQ;
                  o_HADDR  <= head_base_s + step_offset(STEP_A);
                  o_HWRITE <= 1'b1;
                  state_r  <= ST_ADDR;
               end
            end
            ST_ADDR: begin
               o_HTRANS <= HTRANS_IDLE;
               if (step_r != STEP_RES) begin
                  o_HWDATA <= wr_data_s;
               end
               state_r <= ST_DATA;
            end
            ST_DATA: begin
               // An ERROR with HREADY low is the first error cycle: keep waiting
               if (i_HREADY) begin
                  if (slave_err_s) begin
                     rsp_data  <= 32'h0000_0000;
                     rsp_err   <= 1'b1;
                     rsp_valid <= 1'b1;
                     state_r   <= ST_RESP;
                  end else if (step_r == STEP_RES) begin
                     rsp_data  <= i_HRDATA;
                     rsp_err   <= 1'b0;
                     rsp_valid <= 1'b1;
                     state_r   <= ST_RESP;
                  end else begin
                     step_r   <= next_step_s;
                     o_HTRANS <= HTRANS_NONSEQ;
                     o_HADDR  <= work_base_s + step_offset(next_step_s);
                     o_HWRITE <= (next_step_s != STEP_RES);
                     state_r  <= ST_ADDR;
                  end
               end
            end
            ST_RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state_r   <= ST_IDLE;
               end
            end
            default: begin
               o_HTRANS  <= HTRANS_IDLE;
               rsp_valid <= 1'b0;
               state_r   <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ahb_op_sequencer.sv
// Directed bench for ahb_op_sequencer with a small ALU/multiplier slave model.
module tb_ahb_op_sequencer;

   logic        HCLK = 1'b0;
   logic        HRESET = 1'b0;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic        cmd_target = 1'b0;
   logic [3:0]  cmd_op = 4'd0;
   logic [31:0] cmd_a = 32'd0;
   logic [31:0] cmd_b = 32'd0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b1;
   logic [31:0] rsp_data;
   logic        rsp_err;
   logic        busy;
   logic [31:0] o_HADDR;
   logic [31:0] o_HWDATA;
   logic        o_HWRITE;
   logic [2:0]  o_HSIZE;
   logic [2:0]  o_HBURST;
   logic [1:0]  o_HTRANS;
   logic [31:0] i_HRDATA;
   logic [1:0]  i_HRESP;
   logic        i_HREADY;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   // Slave model controls
   logic        err_en   = 1'b0;
   logic [31:0] err_addr = 32'd0;
   int          rd_waits = 0;

   // Slave model state
   logic        dph_r;
   logic [31:0] sa_r;
   logic        sw_r;
   logic        serr_r;
   int          wl_r;
   logic [31:0] alu_a_r, alu_b_r, alu_op_r, mul_a_r, mul_b_r;
   logic [31:0] res_s;
   logic [31:0] addr_q[$];
   logic [31:0] data_q[$];

   ahb_op_sequencer #(
      .CMD_DEPTH (4),
      .ALU_BASE  (32'h0000_0000),
      .MUL_BASE  (32'h0000_1000),
      .W_OP      (4)
   ) dut (
      .HCLK       (HCLK),
      .HRESET     (HRESET),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_target (cmd_target),
      .cmd_op     (cmd_op),
      .cmd_a      (cmd_a),
      .cmd_b      (cmd_b),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_data   (rsp_data),
      .rsp_err    (rsp_err),
      .busy       (busy),
      .o_HADDR    (o_HADDR),
      .o_HWDATA   (o_HWDATA),
      .o_HWRITE   (o_HWRITE),
      .o_HSIZE    (o_HSIZE),
      .o_HBURST   (o_HBURST),
      .o_HTRANS   (o_HTRANS),
      .i_HRDATA   (i_HRDATA),
      .i_HRESP    (i_HRESP),
      .i_HREADY   (i_HREADY)
   );

   always #5 HCLK = ~HCLK;

   always @(posedge HCLK) cyc <= cyc + 1;

   assign res_s    = sa_r[12] ? (mul_a_r * mul_b_r)
                              : ((alu_op_r == 32'd1) ? (alu_a_r - alu_b_r) : (alu_a_r + alu_b_r));
   assign i_HREADY = !dph_r || (wl_r == 0);
   assign i_HRESP  = {1'b0, dph_r && serr_r};
   assign i_HRDATA = (dph_r && !sw_r) ? res_s : 32'h0000_0000;

   // Slave model: captures address phases, inserts waits/errors, stores writes
   always @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         dph_r <= 1'b0; sa_r <= 32'd0; sw_r <= 1'b0; serr_r <= 1'b0; wl_r <= 0;
      end else begin
         if (dph_r) begin
            if (wl_r > 0) begin
               wl_r <= wl_r - 1;
            end else begin
               dph_r <= 1'b0;
               data_q.push_back(sw_r ? o_HWDATA : res_s);
               if (sw_r && !serr_r) begin
                  case (sa_r)
                     32'h0000_0000: alu_a_r  <= o_HWDATA;
                     32'h0000_0004: alu_b_r  <= o_HWDATA;
                     32'h0000_0008: alu_op_r <= o_HWDATA;
                     32'h0000_1000: mul_a_r  <= o_HWDATA;
                     32'h0000_1004: mul_b_r  <= o_HWDATA;
                     default: ;
                  endcase
               end
            end
         end
         if (o_HTRANS == 2'b10) begin
            addr_q.push_back(o_HADDR);
            dph_r  <= 1'b1;
            sa_r   <= o_HADDR;
            sw_r   <= o_HWRITE;
            serr_r <= err_en && (o_HADDR == err_addr);
            wl_r   <= (err_en && (o_HADDR == err_addr)) ? 1 : (o_HWRITE ? 0 : rd_waits);
         end
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic push_cmd(input logic t, input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] b, output int hs);
      int guard = 0;
      @(negedge HCLK);
      cmd_valid = 1'b1; cmd_target = t; cmd_op = op; cmd_a = a; cmd_b = b;
      while (!cmd_ready && guard < 200) begin
         @(negedge HCLK);
         guard++;
      end
      hs = cyc;
      check_eq("push_accept", {31'd0, cmd_ready}, 32'd1);
      @(negedge HCLK);
      cmd_valid = 1'b0;
   endtask

   task automatic wait_rsp(output int rc, output logic ok);
      ok = 1'b0; rc = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge HCLK);
         if (rsp_valid) begin
            ok = 1'b1; rc = cyc;
            break;
         end
      end
   endtask

   logic [31:0] t3_tgt [5] = '{32'd0, 32'd0, 32'd1, 32'd0, 32'd1};
   logic [31:0] t3_op  [5] = '{32'd0, 32'd0, 32'd0, 32'd1, 32'd0};
   logic [31:0] t3_a   [5] = '{32'd1, 32'd10, 32'd4, 32'd100, 32'd6};
   logic [31:0] t3_b   [5] = '{32'd2, 32'd20, 32'd5, 32'd1, 32'd7};
   logic [31:0] t3_exp [5] = '{32'd3, 32'd30, 32'd20, 32'd99, 32'd42};

   initial begin
      int   hs, hs2, rc, h;
      logic ok, saw_rsp;

      HRESET = 1'b1;
      repeat (2) @(negedge HCLK);
      check_eq("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
      check_eq("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      check_eq("rst_rsp_data", rsp_data, 32'd0);
      check_eq("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
      check_eq("rst_busy", {31'd0, busy}, 32'd0);
      check_eq("rst_htrans", {30'd0, o_HTRANS}, 32'd0);
      check_eq("rst_haddr", o_HADDR, 32'd0);
      check_eq("rst_hwdata", o_HWDATA, 32'd0);
      check_eq("rst_hwrite", {31'd0, o_HWRITE}, 32'd0);
      check_eq("hsize", {29'd0, o_HSIZE}, 32'd2);
      check_eq("hburst", {29'd0, o_HBURST}, 32'd0);
      HRESET = 1'b0;
      @(negedge HCLK);

      // ALU add, zero-wait slave
      addr_q.delete(); data_q.delete();
      push_cmd(1'b0, 4'd0, 32'd5, 32'd7, hs);
      wait_rsp(rc, ok);
      check_eq("t1_rsp_seen", {31'd0, ok}, 32'd1);
      check_eq("t1_latency", rc - hs, 32'd10);
      check_eq("t1_rsp_data", rsp_data, 32'd12);
      check_eq("t1_rsp_err", {31'd0, rsp_err}, 32'd0);
      @(negedge HCLK);
      check_eq("t1_rsp_cleared", {31'd0, rsp_valid}, 32'd0);
      check_eq("t1_n_xfer", addr_q.size(), 32'd4);
      check_eq("t1_addr0", addr_q[0], 32'h0);
      check_eq("t1_addr1", addr_q[1], 32'h4);
      check_eq("t1_addr2", addr_q[2], 32'h8);
      check_eq("t1_addr3", addr_q[3], 32'hC);
      check_eq("t1_wdata0", data_q[0], 32'd5);
      check_eq("t1_wdata1", data_q[1], 32'd7);
      check_eq("t1_wdata2", data_q[2], 32'd0);

      // Multiplier with two read wait states
      rd_waits = 2;
      addr_q.delete(); data_q.delete();
      push_cmd(1'b1, 4'd0, 32'd3, 32'd9, hs);
      wait_rsp(rc, ok);
      check_eq("t2_rsp_seen", {31'd0, ok}, 32'd1);
      check_eq("t2_latency", rc - hs, 32'd12);
      check_eq("t2_rsp_data", rsp_data, 32'd27);
      check_eq("t2_read_addr", addr_q[3], 32'h100C);
      rd_waits = 0;
      @(negedge HCLK);

      // FIFO full: five back-to-back pushes with responses held
      rsp_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge HCLK);
         check_eq("t3_ready_before_push", {31'd0, cmd_ready}, 32'd1);
         cmd_valid = 1'b1; cmd_target = t3_tgt[i][0]; cmd_op = t3_op[i][3:0];
         cmd_a = t3_a[i]; cmd_b = t3_b[i];
      end
      @(negedge HCLK);
      cmd_valid = 1'b0;
      check_eq("t3_ready_full", {31'd0, cmd_ready}, 32'd0);
      for (int k = 0; k < 5; k++) begin
         wait_rsp(rc, ok);
         check_eq("t3_rsp_seen", {31'd0, ok}, 32'd1);
         check_eq("t3_rsp_data", rsp_data, t3_exp[k]);
         check_eq("t3_rsp_err", {31'd0, rsp_err}, 32'd0);
         rsp_ready = 1'b1;
         @(negedge HCLK);
         rsp_ready = 1'b0;
      end
      @(negedge HCLK);
      check_eq("t3_busy_done", {31'd0, busy}, 32'd0);
      check_eq("t3_ready_done", {31'd0, cmd_ready}, 32'd1);

      // Slave ERROR on the write to offset 0x4
      rsp_ready = 1'b1; err_en = 1'b1; err_addr = 32'h4;
      addr_q.delete(); data_q.delete();
      push_cmd(1'b0, 4'd0, 32'd8, 32'd9, hs);
      wait_rsp(rc, ok);
      check_eq("t4_rsp_seen", {31'd0, ok}, 32'd1);
      check_eq("t4_rsp_err", {31'd0, rsp_err}, 32'd1);
      check_eq("t4_rsp_data", rsp_data, 32'd0);
      repeat (5) @(negedge HCLK);
      check_eq("t4_n_xfer", addr_q.size(), 32'd2);
      check_eq("t4_last_addr", addr_q[1], 32'h4);
      check_eq("t4_busy", {31'd0, busy}, 32'd0);
      err_en = 1'b0;

      // Response backpressure with a second command queued
      rsp_ready = 1'b0;
      addr_q.delete(); data_q.delete();
      push_cmd(1'b1, 4'd0, 32'd2, 32'd3, hs);
      push_cmd(1'b0, 4'd0, 32'd7, 32'd8, hs2);
      wait_rsp(rc, ok);
      check_eq("t5_rsp_seen", {31'd0, ok}, 32'd1);
      check_eq("t5_rsp1_data", rsp_data, 32'd6);
      repeat (20) @(negedge HCLK);
      check_eq("t5_no_xfer_held", addr_q.size(), 32'd4);
      check_eq("t5_rsp_held", {31'd0, rsp_valid}, 32'd1);
      check_eq("t5_data_held", rsp_data, 32'd6);
      check_eq("t5_htrans_held", {30'd0, o_HTRANS}, 32'd0);
      rsp_ready = 1'b1;
      h = cyc;
      @(negedge HCLK);
      rsp_ready = 1'b0;
      check_eq("t5_idle_after_hs", {30'd0, o_HTRANS}, 32'd0);
      check_eq("t5_rsp_dropped", {31'd0, rsp_valid}, 32'd0);
      check_eq("t5_busy_queued", {31'd0, busy}, 32'd1);
      @(negedge HCLK);
      check_eq("t5_addr0_htrans", {30'd0, o_HTRANS}, 32'd2);
      check_eq("t5_addr0_haddr", o_HADDR, 32'h0);
      wait_rsp(rc, ok);
      check_eq("t5_rsp2_seen", {31'd0, ok}, 32'd1);
      check_eq("t5_rsp2_latency", rc - h, 32'd10);
      check_eq("t5_rsp2_data", rsp_data, 32'd15);
      rsp_ready = 1'b1;
      @(negedge HCLK);

      // Reset during the data phase of step 1, second command queued
      addr_q.delete(); data_q.delete();
      push_cmd(1'b0, 4'd0, 32'd11, 32'd22, hs);
      push_cmd(1'b0, 4'd0, 32'd33, 32'd44, hs2);
      for (int i = 0; i < 50 && cyc < hs + 5; i++) @(negedge HCLK);
      check_eq("t6_in_data1_addr", o_HADDR, 32'h4);
      check_eq("t6_in_data1_htrans", {30'd0, o_HTRANS}, 32'd0);
      check_eq("t6_in_data1_nxfer", addr_q.size(), 32'd2);
      HRESET = 1'b1;
      @(negedge HCLK);
      check_eq("t6_htrans", {30'd0, o_HTRANS}, 32'd0);
      check_eq("t6_busy", {31'd0, busy}, 32'd0);
      check_eq("t6_cmd_ready", {31'd0, cmd_ready}, 32'd1);
      check_eq("t6_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      check_eq("t6_haddr", o_HADDR, 32'd0);
      HRESET = 1'b0;
      saw_rsp = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge HCLK);
         saw_rsp = saw_rsp | rsp_valid;
      end
      check_eq("t6_no_rsp", {31'd0, saw_rsp}, 32'd0);
      check_eq("t6_no_new_xfer", addr_q.size(), 32'd2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
